enemy_missile: RTL
==================

// Module: enemy_missile
// PURPOSE
//  Enemy-side shot controller: return direction of municao1 (enemy fires down at player).
//  Picks a random living enemy from the 3x8 grid, launches one missile from it,
//  moves it down once per frame, detects hits on the player ship, and supplies missile pixels.
//  Sits beside nave/municao1 in SpaceInvaders; RGB is ORed into VGA_R/G/B; hit_player feeds vivo_jogador logic.
// PARAMETERS
//  COL_X0 180 ; COL_STEP 80 ; ROW_Y0 40 ; ROW_STEP 50 : enemy grid origin/pitch (px)
//  ENEMY_W 40 ; ENEMY_H 30 : enemy sprite size (px)
//  MISSILE_W 4 ; MISSILE_H 12 : missile rectangle (px)
//  SPEED 4 : px moved down per frame_tick
//  PLAYER_Y 440 ; PLAYER_W 40 ; PLAYER_H 20 : ship top edge and size (x from posX_Nave)
//  SCREEN_H 480 : missile leaves screen when next Y >= SCREEN_H
//  COOLDOWN 30 : frame_ticks between shots
//  COLOR 24'hFF2020 : missile RGB
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  enable         in   1   game running; low aborts/holds off firing
//  frame_tick     in   1   one-cycle pulse per video frame
//  random_value   in   5   from random_number; sampled on entry to SELECT
//  enemy_alive    in   24  bit k = row*8+col alive
//  posX_Nave      in   11  ship left x
//  h_counter      in   10  current pixel x
//  v_counter      in   10  current pixel y
//  posX_Municao2  out  11  missile left x
//  posY_Municao2  out  11  missile top y
//  tiro_ativo_inimigo out 1 missile in flight
//  shooter_id     out  5   index of last launching enemy
//  hit_player     out  1   one-cycle pulse on ship hit
//  R, G, B        out  8 each  missile pixel colour, 0 elsewhere
// BEHAVIOUR
//  Reset: state IDLE, cooldown=COOLDOWN, all outputs 0.
//  IDLE: on frame_tick with enable, cooldown decrements; when cooldown==0 and enable -> SELECT.
//  SELECT: idx = random_value>=24 ? random_value-24 : random_value; scans=0.
//   One candidate per clock: if enemy_alive[idx] -> launch; else idx wraps 23->0, scans+1.
//   24 failed scans -> IDLE, cooldown reload, no shot.
//  Launch (same cycle as alive hit): col=idx%8, row=idx/8;
//   posX = COL_X0+col*COL_STEP+ENEMY_W/2-MISSILE_W/2; posY = ROW_Y0+row*ROW_STEP+ENEMY_H;
//   shooter_id=idx; tiro_ativo_inimigo=1 from next cycle; -> FLY.
//  FLY, every clock, priority order:
//   1) overlap: posX<posX_Nave+PLAYER_W, posX+MISSILE_W>posX_Nave,
//      posY<PLAYER_Y+PLAYER_H, posY+MISSILE_H>PLAYER_Y -> HIT
//   2) frame_tick: next=posY+SPEED; next>=SCREEN_H -> IDLE (reload) else posY<=next
//  HIT: hit_player=1 exactly one cycle; tiro_ativo_inimigo=0; cooldown reload; -> IDLE.
//  enable low in SELECT/FLY: next clock -> IDLE, tiro_ativo_inimigo=0, cooldown reload, no hit pulse.
//  Reset mid-flight: same as power-up reset; missile disappears next cycle.
//  Position arithmetic in 11 bits, unsigned; no wrap since SCREEN_H<2048.
//  Pixel: registered, 1-cycle latency; RGB=COLOR when tiro_ativo_inimigo and
//   posX<=h_counter<posX+MISSILE_W and posY<=v_counter<posY+MISSILE_H, else 0.
//  Only one missile in flight; enemy_alive changes during FLY do not cancel the missile.
// TESTING
//  1 all alive, random_value=9, cooldown done -> launch cycle 1 of SELECT: shooter_id=9, posX=278, posY=120.
//  2 alive=24'h000001, random_value=5 -> 19 misses then launch idx 0 on 20th SELECT cycle: posX=198, posY=70.
//  3 alive=0 -> 24 SELECT cycles, back to IDLE, tiro_ativo_inimigo never 1, next attempt after 30 ticks.
//  4 launch idx 9, posX_Nave=270 -> posY steps 124,128..432; hit_player one pulse at posY=432, tiro clears.
//  5 launch idx 9, posX_Nave=0 -> posY reaches 476, next tick -> IDLE, no hit_player; RGB=FF,20,20 only at x 278..281, y in [posY,posY+11].
//  6 reset (or enable=0) asserted mid-FLY -> next clock tiro=0, RGB=0, hit_player=0, cooldown=30.

Source files
------------

// File: rtl/enemy_missile.sv
// enemy_missile
//   Enemy-side shot controller. After a cooldown of COOLDOWN frames it picks a
//   living enemy from the 3x8 grid, starting at a random index. It launches one
//   missile from below that enemy and moves it down SPEED px per frame. It
//   reports a hit on the player ship and draws the missile pixels.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   enable              game running; low aborts any shot and holds off firing
//   frame_tick          one-cycle pulse per video frame
//   random_value[4:0]   random start index, sampled on entry to SELECT
//   enemy_alive[23:0]   bit k = row*8+col alive
//   posX_Nave[10:0]     player ship left x
//   h_counter, v_counter[9:0]  current pixel position
//   posX_Municao2, posY_Municao2[10:0]  missile top-left corner
//   tiro_ativo_inimigo  missile in flight
//   shooter_id[4:0]     index of the last launching enemy
//   hit_player          one-cycle pulse when the missile hits the ship
//   R, G, B[7:0]        missile pixel colour (registered), 0 elsewhere
module enemy_missile #(
    parameter int          COL_X0    = 180,
    parameter int          COL_STEP  = 80,
    parameter int          ROW_Y0    = 40,
    parameter int          ROW_STEP  = 50,
    parameter int          ENEMY_W   = 40,
    parameter int          ENEMY_H   = 30,
    parameter int          MISSILE_W = 4,
    parameter int          MISSILE_H = 12,
    parameter int          SPEED     = 4,
    parameter int          PLAYER_Y  = 440,
    parameter int          PLAYER_W  = 40,
    parameter int          PLAYER_H  = 20,
    parameter int          SCREEN_H  = 480,
    parameter int          COOLDOWN  = 30,
    parameter logic [23:0] COLOR     = 24'hFF2020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [4:0]  random_value,
    input  logic [23:0] enemy_alive,
    input  logic [10:0] posX_Nave,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    output logic [10:0] posX_Municao2,
    output logic [10:0] posY_Municao2,
    output logic        tiro_ativo_inimigo,
    output logic [4:0]  shooter_id,
    output logic        hit_player,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    typedef enum logic [1:0] {IDLE, SELECT, FLY, HIT} state_t;

    state_t      state, next_state;
    logic [5:0]  cooldown;
    logic [4:0]  idx;
    logic [4:0]  scans;

    logic [10:0] launch_x, launch_y;
    logic [11:0] mx, my, nx, next_y, hx, vy;
    logic        overlap, off_screen, pixel_on;

    // Launch point: horizontally centred under the enemy sprite, at its bottom edge.
    always_comb begin
        launch_x = 11'(COL_X0 + int'(idx[2:0]) * COL_STEP + ENEMY_W / 2 - MISSILE_W / 2);
        launch_y = 11'(ROW_Y0 + int'(idx[4:3]) * ROW_STEP + ENEMY_H);
    end

    // Geometry in 12 bits so posX_Nave + PLAYER_W cannot wrap.
    always_comb begin
        mx         = {1'b0, posX_Municao2};
        my         = {1'b0, posY_Municao2};
        nx         = {1'b0, posX_Nave};
        hx         = {2'b00, h_counter};
        vy         = {2'b00, v_counter};
        next_y     = my + 12'(SPEED);
        off_screen = frame_tick && (next_y >= 12'(SCREEN_H));
        overlap    = (mx < nx + 12'(PLAYER_W)) && (mx + 12'(MISSILE_W) > nx) &&
                     (my < 12'(PLAYER_Y + PLAYER_H)) && (my + 12'(MISSILE_H) > 12'(PLAYER_Y));
        // Gating with enable blanks the missile on the same edge an abort takes effect.
        pixel_on   = tiro_ativo_inimigo && enable &&
                     (hx >= mx) && (hx < mx + 12'(MISSILE_W)) &&
                     (vy >= my) && (vy < my + 12'(MISSILE_H));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (enable && cooldown == 6'd0) next_state = SELECT;
            SELECT: begin
                if (!enable)                next_state = IDLE;
                else if (enemy_alive[idx])  next_state = FLY;
                else if (scans == 5'd23)    next_state = IDLE;
            end
            FLY: begin
                if (!enable)                next_state = IDLE;
                else if (overlap)           next_state = HIT;
                else if (off_screen)        next_state = IDLE;
            end
            HIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cooldown           <= 6'(COOLDOWN);
            idx                <= '0;
            scans              <= '0;
            posX_Municao2      <= '0;
            posY_Municao2      <= '0;
            shooter_id         <= '0;
            tiro_ativo_inimigo <= 1'b0;
            hit_player         <= 1'b0;
            {R, G, B}          <= '0;
        end else begin
            // Flags follow the next state so they line up with the FSM one cycle later.
            tiro_ativo_inimigo <= (next_state == FLY);
            hit_player         <= (next_state == HIT);
            {R, G, B}          <= pixel_on ? COLOR : 24'h000000;

            case (state)
                IDLE: begin
                    if (next_state == SELECT) begin
                        idx   <= (random_value >= 5'd24) ? random_value - 5'd24 : random_value;
                        scans <= '0;
                    end else if (enable && frame_tick && cooldown != 6'd0) begin
                        cooldown <= cooldown - 6'd1;
                    end
                end
                SELECT: begin
                    if (enable) begin
                        if (enemy_alive[idx]) begin
                            posX_Municao2 <= launch_x;
                            posY_Municao2 <= launch_y;
                            shooter_id    <= idx;
                        end else begin
                            idx   <= (idx == 5'd23) ? 5'd0 : idx + 5'd1;
                            scans <= scans + 5'd1;
                        end
                    end
                end
                FLY: begin
                    if (enable && !overlap && frame_tick && !off_screen)
                        posY_Municao2 <= next_y[10:0];
                end
                default: ;
            endcase

            // Every return to IDLE (miss, exhausted scan, hit, abort) restarts the cooldown.
            if (state != IDLE && next_state == IDLE)
                cooldown <= 6'(COOLDOWN);
        end
    end

endmodule
